// File: rtl/framebuffer.sv
// framebuffer: WIDTH x HEIGHT RGB565 frame store between a drawing client
// (write port) and an OLED driver (read port), with an optional whole-buffer
// fill engine.
//
// Optional feature macro: FRAMEBUFFER_FILL_EN
//   defined   -> IDLE/FILL engine; fill_start paints every pixel with
//                fill_color, one address per clock, and blocks client writes
//   undefined -> no fill logic; fill_start/fill_color ignored,
//                fill_busy = 0, wr_ready = 1
//
// Ports
//   clk, resetn          clock; synchronous active-low reset (RAM is kept)
//   read, row_idx,       pixel request; ack pulses one cycle later with the
//   column_idx           pixel on data_rgb (16'h0000 outside the frame)
//   data_rgb, ack        returned pixel / valid strobe; data_rgb holds
//   wr_en, wr_row,       client pixel write, taken when wr_ready = 1;
//   wr_col, wr_data      out-of-frame writes are consumed and dropped
//   wr_ready             client write port can accept this cycle
//   fill_start,          start a fill with the sampled colour
//   fill_color
//   fill_busy            fill in progress
module framebuffer #(
  parameter int unsigned WIDTH  = 96,
  parameter int unsigned HEIGHT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        read,
  input  logic [5:0]  row_idx,
  input  logic [6:0]  column_idx,
  output logic [15:0] data_rgb,
  output logic        ack,
  input  logic        wr_en,
  input  logic [5:0]  wr_row,
  input  logic [6:0]  wr_col,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        fill_start,
  input  logic [15:0] fill_color,
  output logic        fill_busy
);

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pixel store, row-major; deliberately never cleared.
  logic [DW-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          ack_q, ack_d;
  logic [DW-1:0] data_q, data_d;

  // Address decode and registered return; data holds between acks.
  always_comb begin
    rd_valid = (32'(row_idx) < HEIGHT) && (32'(column_idx) < WIDTH);
    rd_addr  = '0;
    if (rd_valid) begin
      rd_addr = AW'(row_idx) * AW'(WIDTH) + AW'(column_idx);
    end
    ack_d  = read;
    data_d = data_q;
    if (read) begin
      data_d = rd_valid ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q  <= ack_d;
      data_q <= data_d;
    end
  end

  assign ack      = ack_q;
  assign data_rgb = data_q;

  // ---------------------------------------------------------------------
  // Client write decode
  // ---------------------------------------------------------------------
  logic          wr_valid;
  logic [AW-1:0] wr_addr;

  always_comb begin
    wr_valid = (32'(wr_row) < HEIGHT) && (32'(wr_col) < WIDTH);
    wr_addr  = '0;
    if (wr_valid) begin
      wr_addr = AW'(wr_row) * AW'(WIDTH) + AW'(wr_col);
    end
  end

  // ---------------------------------------------------------------------
  // Fill engine
  // ---------------------------------------------------------------------
  logic          fill_we;
  logic [AW-1:0] fill_waddr;
  logic [DW-1:0] fill_wdata;

`ifdef FRAMEBUFFER_FILL_EN
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fill_addr_q, fill_addr_d;
  logic [DW-1:0] fill_color_q, fill_color_d;
  logic          wr_ready_q, wr_ready_d;
  logic          fill_busy_q, fill_busy_d;

  // Next state: one ascending address per clock, back to IDLE on the last.
  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    fill_color_d = fill_color_q;
    fill_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d      = FILL;
          fill_addr_d  = '0;
          fill_color_d = fill_color;
        end
      end
      FILL: begin
        fill_we     = 1'b1;
        fill_addr_d = fill_addr_q + AW'(1);
        if (fill_addr_q == AW'(DEPTH - 1)) begin
          state_d     = IDLE;
          fill_addr_d = '0;
        end
      end
    endcase
    // Status outputs are registered from the next state.
    wr_ready_d  = (state_d == IDLE);
    fill_busy_d = (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      fill_addr_q  <= '0;
      fill_color_q <= '0;
      wr_ready_q   <= 1'b1;
      fill_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      fill_color_q <= fill_color_d;
      wr_ready_q   <= wr_ready_d;
      fill_busy_q  <= fill_busy_d;
    end
  end

  assign fill_waddr = fill_addr_q;
  assign fill_wdata = fill_color_q;
  assign wr_ready   = wr_ready_q;
  assign fill_busy  = fill_busy_q;
`else
  logic unused_fill;

  assign unused_fill = ^{fill_start, fill_color};
  assign fill_we     = 1'b0;
  assign fill_waddr  = '0;
  assign fill_wdata  = '0;
  assign wr_ready    = 1'b1;
  assign fill_busy   = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // RAM write port
  // ---------------------------------------------------------------------
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // Fill owns the port while busy (client is held off by wr_ready); nothing
  // is written on a reset edge, so an aborted fill stops cleanly.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (fill_we) begin
      mem_we    = resetn;
      mem_waddr = fill_waddr;
      mem_wdata = fill_wdata;
    end else if (wr_en && wr_ready && wr_valid) begin
      mem_we = resetn;
    end
  end

  // Read-before-write falls out of the nonblocking update.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_framebuffer.sv
// tb_framebuffer: randomized self-checking bench for framebuffer against a
// flat-array pixel model.
module tb_framebuffer;

  localparam int unsigned W     = 96;
  localparam int unsigned H     = 64;
  localparam int unsigned DEPTH = W * H;

  logic        clk = 1'b0;
  logic        resetn;
  logic        read;
  logic [5:0]  row_idx;
  logic [6:0]  column_idx;
  logic [15:0] data_rgb;
  logic        ack;
  logic        wr_en;
  logic [5:0]  wr_row;
  logic [6:0]  wr_col;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        fill_start;
  logic [15:0] fill_color;
  logic        fill_busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] model [DEPTH];
  logic [15:0] last_data;

  framebuffer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .read       (read),
    .row_idx    (row_idx),
    .column_idx (column_idx),
    .data_rgb   (data_rgb),
    .ack        (ack),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fill_start (fill_start),
    .fill_color (fill_color),
    .fill_busy  (fill_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic logic in_frame(input logic [5:0] r, input logic [6:0] c);
    return (int'(r) < int'(H)) && (int'(c) < int'(W));
  endfunction

  function automatic logic [15:0] ref_read(input logic [5:0] r, input logic [6:0] c);
    if (!in_frame(r, c)) return 16'h0000;
    return model[int'(r) * W + int'(c)];
  endfunction

  // One idle-state clock: drive ports, predict the response, apply the write.
  task automatic tick(input logic rd, input logic [5:0] r, input logic [6:0] c,
                      input logic we, input logic [5:0] wr, input logic [6:0] wc,
                      input logic [15:0] wd,
                      output logic e_ack, output logic [15:0] e_data);
    read       = rd;
    row_idx    = r;
    column_idx = c;
    wr_en      = we;
    wr_row     = wr;
    wr_col     = wc;
    wr_data    = wd;
    e_ack      = rd;
    if (rd) last_data = ref_read(r, c);
    e_data = last_data;
    if (we && in_frame(wr, wc)) model[int'(wr) * W + int'(wc)] = wd;
    @(posedge clk);
    #1;
    read  = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; read = 1'b1; row_idx = '0; column_idx = '0;
    wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    fill_start = 1'b0; fill_color = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    read = 1'b0;
    checks++;
    if (ack !== 1'b0 || data_rgb !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs ack=%b data=%h exp ack=0 data=0000", ack, data_rgb);
    end
    checks++;
    if (wr_ready !== 1'b1 || fill_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_status wr_ready=%b fill_busy=%b exp 1/0", wr_ready, fill_busy);
    end
    resetn = 1'b1;
    last_data = 16'h0000;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_ack ack=%b exp=0", ack);
    end
  endtask

  // Give every pixel a known random value so later reads are predictable.
  task automatic test_init();
    logic ea; logic [15:0] ed;
    for (int a = 0; a < int'(DEPTH); a++) begin
      tick(1'b0, '0, '0, 1'b1, 6'(a / W), 7'(a % W), 16'($urandom), ea, ed);
    end
  endtask

  task automatic test_write_read();
    logic ea; logic [15:0] ed;
    tick(1'b0, '0, '0, 1'b1, 6'd5, 7'd10, 16'hF800, ea, ed);
    tick(1'b1, 6'd5, 7'd10, 1'b0, '0, '0, '0, ea, ed);
    checks++;
    if (ack !== 1'b1 || data_rgb !== 16'hF800) begin
      failures++;
      $display("FAIL write_read ack=%b data=%h exp ack=1 data=f800", ack, data_rgb);
    end
    tick(1'b0, '0, '0, 1'b0, '0, '0, '0, ea, ed);
    checks++;
    if (ack !== 1'b0 || data_rgb !== 16'hF800) begin
      failures++;
      $display("FAIL ack_pulse_hold ack=%b data=%h exp ack=0 data=f800", ack, data_rgb);
    end
  endtask

  // row_idx is 6 bits, so at HEIGHT=64 only columns can fall outside the frame.
  task automatic test_out_of_range();
    logic ea; logic [15:0] ed; logic [15:0] v;
    v = 16'($urandom) | 16'h0001;
    tick(1'b0, '0, '0, 1'b1, 6'd0, 7'd0, v, ea, ed);
    tick(1'b1, 6'd0, 7'd96, 1'b0, '0, '0, '0, ea, ed);
    checks++;
    if (ack !== 1'b1 || data_rgb !== 16'h0000) begin
      failures++;
      $display("FAIL oor_col96 ack=%b data=%h exp ack=1 data=0000", ack, data_rgb);
    end
    tick(1'b1, 6'd0, 7'd0, 1'b0, '0, '0, '0, ea, ed);
    tick(1'b1, 6'd63, 7'd127, 1'b0, '0, '0, '0, ea, ed);
    checks++;
    if (ack !== 1'b1 || data_rgb !== 16'h0000) begin
      failures++;
      $display("FAIL oor_col127 ack=%b data=%h exp ack=1 data=0000", ack, data_rgb);
    end
    tick(1'b0, '0, '0, 1'b1, 6'd0, 7'd96, ~v, ea, ed);
    tick(1'b1, 6'd0, 7'd0, 1'b0, '0, '0, '0, ea, ed);
    checks++;
    if (ack !== 1'b1 || data_rgb !== v) begin
      failures++;
      $display("FAIL oor_write_dropped data=%h exp=%h", data_rgb, v);
    end
  endtask

  task automatic test_back_to_back();
    logic ea; logic [15:0] ed; logic [5:0] r;
    r = 6'($urandom_range(0, 63));
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, '0, '0, 1'b1, r, 7'(i), 16'(i + 1), ea, ed);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, r, 7'(i), 1'b0, '0, '0, '0, ea, ed);
      checks++;
      if (ack !== 1'b1 || data_rgb !== 16'(i + 1)) begin
        failures++;
        $display("FAIL burst_read_%0d ack=%b data=%h exp ack=1 data=%h", i, ack, data_rgb, 16'(i + 1));
      end
    end
    tick(1'b0, '0, '0, 1'b0, '0, '0, '0, ea, ed);
    checks++;
    if (ack !== 1'b0 || data_rgb !== 16'h0004) begin
      failures++;
      $display("FAIL burst_end ack=%b data=%h exp ack=0 data=0004", ack, data_rgb);
    end
  endtask

  task automatic test_read_before_write();
    logic ea; logic [15:0] ed;
    tick(1'b0, '0, '0, 1'b1, 6'd3, 7'd3, 16'h0001, ea, ed);
    tick(1'b1, 6'd3, 7'd3, 1'b1, 6'd3, 7'd3, 16'h0002, ea, ed);
    checks++;
    if (ack !== 1'b1 || data_rgb !== 16'h0001) begin
      failures++;
      $display("FAIL rbw_old ack=%b data=%h exp ack=1 data=0001", ack, data_rgb);
    end
    tick(1'b1, 6'd3, 7'd3, 1'b0, '0, '0, '0, ea, ed);
    checks++;
    if (ack !== 1'b1 || data_rgb !== 16'h0002) begin
      failures++;
      $display("FAIL rbw_new ack=%b data=%h exp ack=1 data=0002", ack, data_rgb);
    end
  endtask

  task automatic test_random();
    logic ea; logic [15:0] ed;
    logic rd, we; logic [5:0] r, wr; logic [6:0] c, wc;
    for (int i = 0; i < 400; i++) begin
      rd = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      r  = 6'($urandom_range(0, 3));
      c  = 7'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) begin
        r = 6'($urandom);
        c = 7'($urandom);
      end
      wr = 6'($urandom_range(0, 3));
      wc = 7'($urandom_range(0, 99));
      if ($urandom_range(0, 4) == 0) begin
        wr = r;
        wc = c;
      end
      tick(rd, r, c, we, wr, wc, 16'($urandom), ea, ed);
      checks++;
      if (ack !== ea || data_rgb !== ed) begin
        failures++;
        $display("FAIL random_%0d ack=%b data=%h exp ack=%b data=%h", i, ack, data_rgb, ea, ed);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic ea; logic [15:0] ed;
    tick(1'b0, '0, '0, 1'b1, 6'd1, 7'd1, 16'hABCD, ea, ed);
    tick(1'b1, 6'd1, 7'd1, 1'b0, '0, '0, '0, ea, ed);
    resetn = 1'b0;
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    checks++;
    if (ack !== 1'b0 || data_rgb !== 16'h0000) begin
      failures++;
      $display("FAIL midrun_reset ack=%b data=%h exp ack=0 data=0000", ack, data_rgb);
    end
    resetn = 1'b1;
    last_data = 16'h0000;
    tick(1'b1, 6'd1, 7'd1, 1'b0, '0, '0, '0, ea, ed);
    checks++;
    if (ack !== 1'b1 || data_rgb !== 16'hABCD) begin
      failures++;
      $display("FAIL ram_kept_on_reset data=%h exp=abcd", data_rgb);
    end
  endtask

`ifdef FRAMEBUFFER_FILL_EN
  task automatic test_fill();
    logic ea; logic [15:0] ed;
    logic [5:0] r; logic [6:0] c;
    int busy_cycles;
    // Client write on the start edge is taken, then painted over.
    fill_start = 1'b1;
    fill_color = 16'h07E0;
    tick(1'b0, '0, '0, 1'b1, 6'd2, 7'd2, 16'h1111, ea, ed);
    fill_start = 1'b0;
    checks++;
    if (fill_busy !== 1'b1 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_enter busy=%b wr_ready=%b exp 1/0", fill_busy, wr_ready);
    end
    busy_cycles = (fill_busy === 1'b1) ? 1 : 0;
    for (int j = 1; j <= int'(DEPTH); j++) begin
      fill_color = 16'($urandom);
      fill_start = 1'($urandom_range(0, 1));
      r = 6'($urandom_range(0, 63));
      c = 7'($urandom_range(0, 100));
      read = 1'b1; row_idx = r; column_idx = c;
      wr_en = 1'b1; wr_row = 6'($urandom); wr_col = 7'($urandom); wr_data = 16'($urandom);
      ed = ref_read(r, c);
      last_data = ed;
      model[j - 1] = 16'h07E0;
      @(posedge clk); #1;
      if (fill_busy === 1'b1) busy_cycles++;
      checks++;
      if (ack !== 1'b1 || data_rgb !== ed) begin
        failures++;
        $display("FAIL fill_read_%0d ack=%b data=%h exp ack=1 data=%h", j, ack, data_rgb, ed);
      end
    end
    read = 1'b0; wr_en = 1'b0; fill_start = 1'b0;
    checks++;
    if (busy_cycles != int'(DEPTH)) begin
      failures++;
      $display("FAIL fill_busy_len got=%0d exp=%0d", busy_cycles, DEPTH);
    end
    checks++;
    if (fill_busy !== 1'b0 || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_exit busy=%b wr_ready=%b exp 0/1", fill_busy, wr_ready);
    end
    for (int a = 0; a < int'(DEPTH); a++) begin
      tick(1'b1, 6'(a / W), 7'(a % W), 1'b0, '0, '0, '0, ea, ed);
      checks++;
      if (ack !== 1'b1 || data_rgb !== 16'h07E0) begin
        failures++;
        $display("FAIL fill_readback_%0d ack=%b data=%h exp ack=1 data=07e0", a, ack, data_rgb);
      end
    end
  endtask

  task automatic test_fill_reset();
    logic ea; logic [15:0] ed;
    for (int a = 0; a < 128; a++) begin
      tick(1'b0, '0, '0, 1'b1, 6'(a / W), 7'(a % W), 16'h8000 | 16'(a), ea, ed);
    end
    fill_start = 1'b1;
    fill_color = 16'h07E0;
    tick(1'b0, '0, '0, 1'b0, '0, '0, '0, ea, ed);
    fill_start = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    checks++;
    if (fill_busy !== 1'b0 || wr_ready !== 1'b1 || ack !== 1'b0) begin
      failures++;
      $display("FAIL fill_abort busy=%b wr_ready=%b ack=%b exp 0/1/0", fill_busy, wr_ready, ack);
    end
    resetn = 1'b1;
    last_data = 16'h0000;
    for (int a = 0; a < 102; a++) begin
      tick(1'b1, 6'(a / W), 7'(a % W), 1'b0, '0, '0, '0, ea, ed);
      checks++;
      if (ack !== 1'b1 || data_rgb !== ((a < 100) ? 16'h07E0 : (16'h8000 | 16'(a)))) begin
        failures++;
        $display("FAIL fill_abort_pix_%0d data=%h exp=%h", a, data_rgb,
                 (a < 100) ? 16'h07E0 : (16'h8000 | 16'(a)));
      end
    end
  endtask
`else
  task automatic test_fill_disabled();
    logic ea; logic [15:0] ed;
    fill_start = 1'b1;
    fill_color = 16'h07E0;
    tick(1'b0, '0, '0, 1'b1, 6'd9, 7'd9, 16'h5A5A, ea, ed);
    fill_start = 1'b0;
    checks++;
    if (fill_busy !== 1'b0 || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL nofill_status busy=%b wr_ready=%b exp 0/1", fill_busy, wr_ready);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, '0, '0, 1'b0, '0, '0, '0, ea, ed);
    end
    tick(1'b1, 6'd9, 7'd9, 1'b0, '0, '0, '0, ea, ed);
    checks++;
    if (ack !== 1'b1 || data_rgb !== 16'h5A5A) begin
      failures++;
      $display("FAIL nofill_pixel data=%h exp=5a5a", data_rgb);
    end
    tick(1'b1, 6'd9, 7'd10, 1'b0, '0, '0, '0, ea, ed);
    checks++;
    if (ack !== 1'b1 || data_rgb !== ed) begin
      failures++;
      $display("FAIL nofill_neighbour data=%h exp=%h", data_rgb, ed);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_out_of_range();
    test_back_to_back();
    test_read_before_write();
    test_random();
    test_reset_midrun();
`ifdef FRAMEBUFFER_FILL_EN
    test_fill();
    test_fill_reset();
`else
    test_fill_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
